// File: rtl/instr_encoder_if.sv
// Request/response bundle between a requester and the RV32IM instruction encoder.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32IM instruction encoder: combinational field packing and range checks feeding
// a 2-entry output FIFO, with accepted-request and error counters.
module instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    instr_encoder_if.slave   bus,
    output logic [CNT_W-1:0] enc_count,
    output logic [7:0]       err_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // True when the bits above position sh are pure sign extension.
    function automatic logic sign_fits(input logic signed [31:0] v, input int unsigned sh);
        logic signed [31:0] hi;
        hi = v >>> sh;
        return (hi == 32'sd0) || (hi == -32'sd1);
    endfunction

    logic signed [31:0] imm_p0;
    logic [31:0]        word_p0;
    logic               err_p0;
    logic               push, pop;

    logic [31:0] instr_p1 [2];
    logic        err_p1   [2];
    logic [1:0]  occ_p1;
    logic        wr_ptr_p1, rd_ptr_p1;
    logic        ready_en;

    assign imm_p0 = bus.in_imm;

    // Stage p0: combinational encode of the presented request
    always_comb begin
        word_p0 = NOP;
        err_p0  = 1'b0;
        case (bus.in_op)
            4'd0, 4'd1, 4'd3, 4'd7: begin
                err_p0 = !sign_fits(imm_p0, 11);
                case (bus.in_op)
                    4'd0:    word_p0 = {imm_p0[11:0], bus.in_rs1, 3'b000, bus.in_rd, 7'b0010011};
                    4'd1:    word_p0 = {imm_p0[11:0], bus.in_rs1, 3'b111, bus.in_rd, 7'b0010011};
                    4'd3:    word_p0 = {imm_p0[11:0], bus.in_rs1, 3'b010, bus.in_rd, 7'b0000011};
                    default: word_p0 = {imm_p0[11:0], bus.in_rs1, 3'b000, bus.in_rd, 7'b1100111};
                endcase
            end
            4'd2: begin
                err_p0  = (imm_p0 >>> 5) != 32'sd0;
                word_p0 = {7'b0000000, imm_p0[4:0], bus.in_rs1, 3'b001, bus.in_rd, 7'b0010011};
            end
            4'd4: begin
                err_p0  = !sign_fits(imm_p0, 11);
                word_p0 = {imm_p0[11:5], bus.in_rs2, bus.in_rs1, 3'b010, imm_p0[4:0], 7'b0100011};
            end
            4'd5: begin
                err_p0  = !sign_fits(imm_p0, 12) || imm_p0[0];
                word_p0 = {imm_p0[12], imm_p0[10:5], bus.in_rs2, bus.in_rs1, 3'b001,
                           imm_p0[4:1], imm_p0[11], 7'b1100011};
            end
            4'd6: begin
                err_p0  = !sign_fits(imm_p0, 20) || imm_p0[0];
                word_p0 = {imm_p0[20], imm_p0[10:1], imm_p0[11], imm_p0[19:12], bus.in_rd, 7'b1101111};
            end
            4'd8, 4'd9: begin
                err_p0  = imm_p0[11:0] != 12'd0;
                word_p0 = {imm_p0[31:12], bus.in_rd, (bus.in_op == 4'd8) ? 7'b0110111 : 7'b0010111};
            end
            4'd10:   word_p0 = {7'b0000001, bus.in_rs2, bus.in_rs1, 3'b000, bus.in_rd, 7'b0110011};
            default: err_p0 = 1'b1;
        endcase
        if (err_p0) word_p0 = NOP;
    end

    // ready_en keeps in_ready low until the first edge after reset release
    assign bus.in_ready  = ready_en && (occ_p1 != 2'd2);
    assign bus.out_valid = (occ_p1 != 2'd0);
    assign bus.out_instr = bus.out_valid ? instr_p1[rd_ptr_p1] : 32'd0;
    assign bus.out_err   = bus.out_valid ? err_p1[rd_ptr_p1] : 1'b0;
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // Stage p1: FIFO control and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en  <= 1'b0;
            occ_p1    <= 2'd0;
            wr_ptr_p1 <= 1'b0;
            rd_ptr_p1 <= 1'b0;
            enc_count <= '0;
            err_count <= 8'd0;
        end else begin
            ready_en <= 1'b1;
            occ_p1   <= occ_p1 + {1'b0, push} - {1'b0, pop};
            if (push) begin
                wr_ptr_p1 <= ~wr_ptr_p1;
                enc_count <= enc_count + CNT_W'(1);
                if (err_p0) err_count <= sat_inc8(err_count);
            end
            if (pop) rd_ptr_p1 <= ~rd_ptr_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_p1[wr_ptr_p1] <= word_p0;
            err_p1[wr_ptr_p1]   <= err_p0;
        end
    end

endmodule
